// File: rtl/hongwai_rx.sv
`default_nettype none
// ============================================================================
// Module      : hongwai_rx
// Description : Infrared receiver/decoder for the air-conditioner remote link.
//               Synchronizes and de-glitches the demodulated IR pin, measures
//               mark/space durations in 10 us ticks and decodes the frame
//               leader / 35-bit segment / connector / 32-bit segment / end
//               mark, presenting both words with a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module hongwai_rx #(
  parameter int TICK_DIV = 500,   // clk cycles per duration tick
  parameter int GLITCH   = 16,    // cycles a new level must hold to be accepted
  parameter int TIMEOUT  = 2500   // ticks without an edge that abort a frame
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IR_in,
  output logic [34:0] data35_out,
  output logic [31:0] data32_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy,
  output logic        led_out
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GLITCH + 1);

  localparam logic [PW-1:0] C_PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] C_GLITCH_MAX = GW'(GLITCH - 1);
  localparam logic [11:0]   C_TIMEOUT_M1 = 12'(TIMEOUT - 1);
  localparam logic [11:0]   C_CNT_SAT    = 12'd4095;

  // Duration windows in ticks, both bounds inclusive
  localparam logic [11:0] C_LM_MIN  = 12'd800;
  localparam logic [11:0] C_LM_MAX  = 12'd1000;
  localparam logic [11:0] C_LS_MIN  = 12'd400;
  localparam logic [11:0] C_LS_MAX  = 12'd500;
  localparam logic [11:0] C_BM_MIN  = 12'd40;
  localparam logic [11:0] C_BM_MAX  = 12'd80;
  localparam logic [11:0] C_ZS_MIN  = 12'd40;
  localparam logic [11:0] C_ZS_MAX  = 12'd80;
  localparam logic [11:0] C_OS_MIN  = 12'd140;
  localparam logic [11:0] C_OS_MAX  = 12'd200;
  localparam logic [11:0] C_CS_MIN  = 12'd1800;
  localparam logic [11:0] C_CS_MAX  = 12'd2200;

  localparam logic [5:0] C_SEG0_LEN = 6'd35;
  localparam logic [5:0] C_SEG1_LEN = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_MARK       = 3'd3,
    S_SPACE      = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic          ir_s1_q;
  logic          ir_s2_q;
  logic          filt_q;
  logic          filt_prev_q;
  logic [GW-1:0] gcnt_q;
  logic [PW-1:0] presc_q;
  logic [11:0]   tick_cnt_q;

  state_t        state_q,  state_d;
  logic          seg_q,    seg_d;
  logic [5:0]    cnt_q,    cnt_d;
  logic [34:0]   sh35_q,   sh35_d;
  logic [31:0]   sh32_q,   sh32_d;
  logic [34:0]   data35_q, data35_d;
  logic [31:0]   data32_q, data32_d;
  logic          valid_q,  valid_d;
  logic          err_q,    err_d;
  logic          led_q,    led_d;

  logic          w_edge;
  logic          w_rise;
  logic          w_fall;
  logic          w_tick;
  logic          w_timeout;
  logic [11:0]   w_dur;
  logic          w_lead_mark;
  logic          w_lead_space;
  logic          w_bit_mark;
  logic          w_zero;
  logic          w_one;
  logic          w_conn;
  logic [5:0]    w_seg_len;

  function automatic logic in_win(input logic [11:0] v,
                                  input logic [11:0] lo,
                                  input logic [11:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------

  // Two-stage synchronizer; the idle line level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_s1_q <= 1'b1;
      ir_s2_q <= 1'b1;
    end else begin
      ir_s1_q <= IR_in;
      ir_s2_q <= ir_s1_q;
    end
  end

  // Stable-level filter: adopt the synchronized level only after it has
  // disagreed with the filtered level for GLITCH consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      gcnt_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (ir_s2_q != filt_q) begin
        if (gcnt_q == C_GLITCH_MAX) begin
          filt_q <= ir_s2_q;
          gcnt_q <= '0;
        end else begin
          gcnt_q <= gcnt_q + 1'b1;
        end
      end else begin
        gcnt_q <= '0;
      end
    end
  end

  // Edges are seen one cycle after the filtered level changes.
  assign w_edge = filt_q ^ filt_prev_q;
  assign w_rise = w_edge & filt_q;
  assign w_fall = w_edge & ~filt_q;

  // --------------------------------------------------------------------------
  // Duration measurement
  // --------------------------------------------------------------------------
  assign w_tick = (presc_q == C_PRESC_MAX) && !w_edge;

  // Tick prescaler; restarts on every filtered edge so each segment is
  // measured from its own start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (w_edge || (presc_q == C_PRESC_MAX)) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Saturating tick counter holding the length of the current segment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (w_edge) begin
      tick_cnt_q <= '0;
    end else if (w_tick && (tick_cnt_q != C_CNT_SAT)) begin
      tick_cnt_q <= tick_cnt_q + 12'd1;
    end
  end

  // The counter still holds the finished segment's length in the edge cycle.
  assign w_dur        = tick_cnt_q;
  assign w_lead_mark  = in_win(w_dur, C_LM_MIN, C_LM_MAX);
  assign w_lead_space = in_win(w_dur, C_LS_MIN, C_LS_MAX);
  assign w_bit_mark   = in_win(w_dur, C_BM_MIN, C_BM_MAX);
  assign w_zero       = in_win(w_dur, C_ZS_MIN, C_ZS_MAX);
  assign w_one        = in_win(w_dur, C_OS_MIN, C_OS_MAX);
  assign w_conn       = in_win(w_dur, C_CS_MIN, C_CS_MAX);
  assign w_seg_len    = seg_q ? C_SEG1_LEN : C_SEG0_LEN;

  // Timeout fires on the tick that brings the counter to TIMEOUT.
  assign w_timeout = (state_q != S_IDLE) && w_tick && (tick_cnt_q == C_TIMEOUT_M1);

  // --------------------------------------------------------------------------
  // Frame decoder
  // --------------------------------------------------------------------------

  // Decoder state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      seg_q    <= 1'b0;
      cnt_q    <= '0;
      sh35_q   <= '0;
      sh32_q   <= '0;
      data35_q <= '0;
      data32_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      cnt_q    <= cnt_d;
      sh35_q   <= sh35_d;
      sh32_q   <= sh32_d;
      data35_q <= data35_d;
      data32_q <= data32_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      led_q    <= led_d;
    end
  end

  // Next-state logic: walk the frame edge by edge, classifying each segment.
  // A timeout takes priority over an edge in the same cycle, so that edge is
  // never mistaken for a new leader.
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    cnt_d    = cnt_q;
    sh35_d   = sh35_q;
    sh32_d   = sh32_q;
    data35_d = data35_q;
    data32_d = data32_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    led_d    = led_q;

    if (w_timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_fall) begin
            state_d = S_LEAD_MARK;
          end
        end

        // A mark of the wrong length is not a leader: drop back silently.
        S_LEAD_MARK: begin
          if (w_rise) begin
            state_d = w_lead_mark ? S_LEAD_SPACE : S_IDLE;
          end
        end

        S_LEAD_SPACE: begin
          if (w_fall) begin
            if (w_lead_space) begin
              state_d = S_MARK;
              seg_d   = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end
        end

        S_MARK: begin
          if (w_rise) begin
            if (!w_bit_mark) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end else if (seg_q && (cnt_q == C_SEG1_LEN)) begin
              // End mark of the second segment: publish the frame.
              state_d  = S_IDLE;
              data35_d = sh35_q;
              data32_d = sh32_q;
              valid_d  = 1'b1;
              led_d    = ~led_q;
            end else begin
              state_d = S_SPACE;
            end
          end
        end

        S_SPACE: begin
          if (w_fall) begin
            if (!seg_q && (cnt_q == C_SEG0_LEN)) begin
              if (w_conn) begin
                state_d = S_MARK;
                seg_d   = 1'b1;
                cnt_d   = '0;
              end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end
            end else if ((cnt_q < w_seg_len) && (w_zero || w_one)) begin
              if (seg_q) begin
                sh32_d = {sh32_q[30:0], w_one};
              end else begin
                sh35_d = {sh35_q[33:0], w_one};
              end
              cnt_d   = cnt_q + 6'd1;
              state_d = S_MARK;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data35_out  = data35_q;
  assign data32_out  = data32_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign led_out     = led_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hongwai_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hongwai_rx
// Description : Self-checking bench for hongwai_rx. Frames are described as
//               lists of mark/space durations; a reference decoder applies the
//               timing windows to the list to predict the published words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hongwai_rx;

  // One tick per clock keeps whole frames short while the tick windows
  // stay at their real values.
  localparam int TICK_DIV = 1;
  localparam int GLITCH   = 4;
  localparam int TIMEOUT  = 2500;

  logic        clk = 1'b0;
  logic        rst;
  logic        IR_in;
  logic [34:0] data35_out;
  logic [31:0] data32_out;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;
  logic        led_out;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  // Reference state: what the outputs should be holding
  logic [34:0] m_d35;
  logic [31:0] m_d32;
  logic        m_led;

  // Current frame as alternating durations in ticks, starting with a mark
  int fq[$];
  logic busy_mid;

  hongwai_rx #(
    .TICK_DIV(TICK_DIV),
    .GLITCH  (GLITCH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .IR_in      (IR_in),
    .data35_out (data35_out),
    .data32_out (data32_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .led_out    (led_out)
  );

  always #10 clk = ~clk;

  // Count strobe cycles; a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_err)   n_err++;
  end

  function automatic bit inw(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Random duration comfortably inside a window starting at lo
  function automatic int rdur(input int lo);
    return lo + 2 + int'($urandom_range(8));
  endfunction

  // Reference decoder: apply the frame rules to the duration list.
  function automatic bit ref_decode(output logic [34:0] w35, output logic [31:0] w32);
    w35 = '0;
    w32 = '0;
    if (fq.size() != 139) return 1'b0;
    if (!inw(fq[0], 800, 1000) || !inw(fq[1], 400, 500)) return 1'b0;
    for (int b = 0; b < 35; b++) begin
      if (!inw(fq[2 + 2*b], 40, 80)) return 1'b0;
      if (inw(fq[3 + 2*b], 40, 80))        w35[34 - b] = 1'b0;
      else if (inw(fq[3 + 2*b], 140, 200)) w35[34 - b] = 1'b1;
      else return 1'b0;
    end
    if (!inw(fq[72], 40, 80) || !inw(fq[73], 1800, 2200)) return 1'b0;
    for (int b = 0; b < 32; b++) begin
      if (!inw(fq[74 + 2*b], 40, 80)) return 1'b0;
      if (inw(fq[75 + 2*b], 40, 80))        w32[31 - b] = 1'b0;
      else if (inw(fq[75 + 2*b], 140, 200)) w32[31 - b] = 1'b1;
      else return 1'b0;
    end
    if (!inw(fq[138], 40, 80)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic build_frame(input logic [34:0] d35, input logic [31:0] d32, input bit nominal);
    fq.delete();
    fq.push_back(nominal ? 900 : rdur(800));
    fq.push_back(nominal ? 450 : rdur(400));
    for (int b = 0; b < 35; b++) begin
      fq.push_back(nominal ? 56 : rdur(40));
      if (d35[34 - b]) fq.push_back(nominal ? 169 : rdur(140));
      else             fq.push_back(nominal ? 56  : rdur(40));
    end
    fq.push_back(nominal ? 56 : rdur(40));
    fq.push_back(nominal ? 2000 : rdur(1800));
    for (int b = 0; b < 32; b++) begin
      fq.push_back(nominal ? 56 : rdur(40));
      if (d32[31 - b]) fq.push_back(nominal ? 169 : rdur(140));
      else             fq.push_back(nominal ? 56  : rdur(40));
    end
    fq.push_back(nominal ? 56 : rdur(40));
  endtask

  // Drive the first n durations of fq onto the pin, then leave it high.
  task automatic drive_frame(input int n, input bit glitch);
    int g;
    for (int i = 0; i < n; i++) begin
      if ((i % 2) == 0) begin
        IR_in = 1'b0;
        repeat (fq[i]) @(negedge clk);
      end else if (glitch && (fq[i] >= 30)) begin
        g = 1 + int'($urandom_range(GLITCH - 2));
        IR_in = 1'b1;
        repeat (10) @(negedge clk);
        IR_in = 1'b0;
        repeat (g) @(negedge clk);
        IR_in = 1'b1;
        repeat (fq[i] - 10 - g) @(negedge clk);
      end else begin
        IR_in = 1'b1;
        repeat (fq[i]) @(negedge clk);
      end
      if (i == 0) busy_mid = busy;
    end
    IR_in = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    IR_in = 1'b1;
    m_d35 = '0;
    m_d32 = '0;
    m_led = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (data35_out !== 35'h0) begin errors++; $display("FAIL reset_d35: got %h expected 0", data35_out); end
    checks++; if (data32_out !== 32'h0) begin errors++; $display("FAIL reset_d32: got %h expected 0", data32_out); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    checks++; if (frame_err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (led_out !== 1'b0)     begin errors++; $display("FAIL reset_led: got %b expected 0", led_out); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_clean_frame();
    logic [34:0] w35;
    logic [31:0] w32;
    bit ok;
    int v0, e0;
    build_frame(35'h7C1F07C1F, 32'hF83E0F83, 1'b1);
    ok = ref_decode(w35, w32);
    v0 = n_valid; e0 = n_err;
    drive_frame(fq.size(), 1'b0);
    repeat (30) @(negedge clk);
    if (ok) begin m_d35 = w35; m_d32 = w32; m_led = ~m_led; end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL clean_busy_mid: got %b expected 1", busy_mid); end
    checks++; if (n_valid - v0 != (ok ? 1 : 0)) begin errors++; $display("FAIL clean_valid_cnt: got %0d expected %0d", n_valid - v0, ok ? 1 : 0); end
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL clean_err_cnt: got %0d expected 0", n_err - e0); end
    checks++; if (data35_out !== m_d35) begin errors++; $display("FAIL clean_d35: got %h expected %h", data35_out, m_d35); end
    checks++; if (data32_out !== m_d32) begin errors++; $display("FAIL clean_d32: got %h expected %h", data32_out, m_d32); end
    checks++; if (led_out !== m_led) begin errors++; $display("FAIL clean_led: got %b expected %b", led_out, m_led); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_glitch();
    logic [34:0] w35;
    logic [31:0] w32;
    bit ok;
    bit busy_seen;
    int v0, e0, g;
    v0 = n_valid; e0 = n_err;
    busy_seen = 1'b0;
    for (int p = 0; p < 20; p++) begin
      g = 1 + int'($urandom_range(GLITCH - 2));
      IR_in = 1'b1;
      repeat (20) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
      IR_in = 1'b0;
      repeat (g) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
    end
    IR_in = 1'b1;
    repeat (20) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL glitch_idle_busy: got %b expected 0", busy_seen); end
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL glitch_idle_err: got %0d expected 0", n_err - e0); end
    build_frame({$urandom, $urandom} & 35'h7FFFFFFFF, $urandom, 1'b0);
    ok = ref_decode(w35, w32);
    drive_frame(fq.size(), 1'b1);
    repeat (30) @(negedge clk);
    if (ok) begin m_d35 = w35; m_d32 = w32; m_led = ~m_led; end
    checks++; if (n_valid - v0 != (ok ? 1 : 0)) begin errors++; $display("FAIL glitch_valid_cnt: got %0d expected %0d", n_valid - v0, ok ? 1 : 0); end
    checks++; if (data35_out !== m_d35) begin errors++; $display("FAIL glitch_d35: got %h expected %h", data35_out, m_d35); end
    checks++; if (data32_out !== m_d32) begin errors++; $display("FAIL glitch_d32: got %h expected %h", data32_out, m_d32); end
    checks++; if (led_out !== m_led) begin errors++; $display("FAIL glitch_led: got %b expected %b", led_out, m_led); end
  endtask

  task automatic test_bad_leader();
    logic [34:0] w35;
    logic [31:0] w32;
    bit ok;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    IR_in = 1'b0;
    repeat (500) @(negedge clk);
    IR_in = 1'b1;
    repeat (450) @(negedge clk);
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL badlead_err: got %0d expected 0", n_err - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badlead_busy: got %b expected 0", busy); end
    checks++; if (data35_out !== m_d35) begin errors++; $display("FAIL badlead_d35: got %h expected %h", data35_out, m_d35); end
    build_frame({$urandom, $urandom} & 35'h7FFFFFFFF, $urandom, 1'b0);
    ok = ref_decode(w35, w32);
    drive_frame(fq.size(), 1'b0);
    repeat (30) @(negedge clk);
    if (ok) begin m_d35 = w35; m_d32 = w32; m_led = ~m_led; end
    checks++; if (n_valid - v0 != (ok ? 1 : 0)) begin errors++; $display("FAIL badlead_next_valid: got %0d expected %0d", n_valid - v0, ok ? 1 : 0); end
    checks++; if (data35_out !== m_d35) begin errors++; $display("FAIL badlead_next_d35: got %h expected %h", data35_out, m_d35); end
    checks++; if (data32_out !== m_d32) begin errors++; $display("FAIL badlead_next_d32: got %h expected %h", data32_out, m_d32); end
  endtask

  task automatic test_bad_bit();
    logic [34:0] w35;
    logic [31:0] w32;
    bit ok;
    int v0, e0;
    build_frame({$urandom, $urandom} & 35'h7FFFFFFFF, $urandom, 1'b0);
    fq[3 + 2*10] = 110;
    ok = ref_decode(w35, w32);
    v0 = n_valid; e0 = n_err;
    drive_frame(25, 1'b0);
    repeat (30) @(negedge clk);
    if (ok) begin m_d35 = w35; m_d32 = w32; m_led = ~m_led; end
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL badbit_err: got %0d expected 1", n_err - e0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL badbit_valid: got %0d expected 0", n_valid - v0); end
    checks++; if (data35_out !== m_d35) begin errors++; $display("FAIL badbit_d35: got %h expected %h", data35_out, m_d35); end
    checks++; if (data32_out !== m_d32) begin errors++; $display("FAIL badbit_d32: got %h expected %h", data32_out, m_d32); end
    checks++; if (led_out !== m_led) begin errors++; $display("FAIL badbit_led: got %b expected %b", led_out, m_led); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badbit_busy: got %b expected 0", busy); end
  endtask

  task automatic test_truncated();
    int v0, e0, k;
    bit busy_at_err;
    build_frame({$urandom, $urandom} & 35'h7FFFFFFFF, $urandom, 1'b0);
    v0 = n_valid; e0 = n_err;
    // leader, 35 bits, connector, 20 bits of segment two, one more mark
    drive_frame(115, 1'b0);
    k = 0;
    busy_at_err = 1'b1;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      if (frame_err) begin
        k = c;
        busy_at_err = busy;
        break;
      end
    end
    checks++;
    if ((k < TIMEOUT * TICK_DIV) || (k > TIMEOUT * TICK_DIV + GLITCH + 6)) begin
      errors++;
      $display("FAIL trunc_latency: got %0d cycles expected %0d..%0d", k, TIMEOUT * TICK_DIV, TIMEOUT * TICK_DIV + GLITCH + 6);
    end
    checks++; if (busy_at_err !== 1'b0) begin errors++; $display("FAIL trunc_busy: got %b expected 0", busy_at_err); end
    repeat (30) @(negedge clk);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL trunc_err_cnt: got %0d expected 1", n_err - e0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL trunc_valid: got %0d expected 0", n_valid - v0); end
    checks++; if (data35_out !== m_d35) begin errors++; $display("FAIL trunc_d35: got %h expected %h", data35_out, m_d35); end
  endtask

  task automatic test_reset_mid();
    logic [34:0] w35;
    logic [31:0] w32;
    bit ok;
    int v0, e0;
    build_frame({$urandom, $urandom} & 35'h7FFFFFFFF, $urandom, 1'b0);
    e0 = n_err;
    drive_frame(73, 1'b0);
    repeat (1000) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    m_d35 = '0; m_d32 = '0; m_led = 1'b0;
    checks++; if (data35_out !== m_d35) begin errors++; $display("FAIL rstmid_d35: got %h expected 0", data35_out); end
    checks++; if (data32_out !== m_d32) begin errors++; $display("FAIL rstmid_d32: got %h expected 0", data32_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (led_out !== m_led) begin errors++; $display("FAIL rstmid_led: got %b expected 0", led_out); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL rstmid_err: got %0d expected 0", n_err - e0); end
    build_frame({$urandom, $urandom} & 35'h7FFFFFFFF, $urandom, 1'b0);
    ok = ref_decode(w35, w32);
    v0 = n_valid;
    drive_frame(fq.size(), 1'b0);
    repeat (30) @(negedge clk);
    if (ok) begin m_d35 = w35; m_d32 = w32; m_led = ~m_led; end
    checks++; if (n_valid - v0 != (ok ? 1 : 0)) begin errors++; $display("FAIL rstmid_next_valid: got %0d expected %0d", n_valid - v0, ok ? 1 : 0); end
    checks++; if (data35_out !== m_d35) begin errors++; $display("FAIL rstmid_next_d35: got %h expected %h", data35_out, m_d35); end
    checks++; if (data32_out !== m_d32) begin errors++; $display("FAIL rstmid_next_d32: got %h expected %h", data32_out, m_d32); end
    checks++; if (led_out !== m_led) begin errors++; $display("FAIL rstmid_next_led: got %b expected %b", led_out, m_led); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_bad_leader();
    test_bad_bit();
    test_truncated();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hongwai_rx.md
# hongwai_rx

Infrared receiver/decoder for the air-conditioner remote link: the counterpart of the existing IR transmitter. It takes the demodulated output of an IR receiver module, measures mark/space durations, and decodes the two-segment frame: leader, 35-bit segment, connector, 32-bit segment, end mark. On a clean frame it presents both data words with a one-cycle valid strobe; malformed frames produce an error strobe. It sits between the board IR receiver pin and the control/display logic, on the same 50 MHz clock as the transmitter.

## Interface
- TICK_DIV, 500: clk cycles per time tick (10 µs at 50 MHz).
- GLITCH, 16: cycles a synchronized input level must hold before it is accepted.
- TIMEOUT, 2500: ticks without a filtered edge that abort a frame in progress.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- IR_in  in  1  demodulated IR input, active-low: 0 = mark (carrier present), 1 = space.
- data35_out  out  35  last valid first segment; the first received bit is bit 34.
- data32_out  out  32  last valid second segment; the first received bit is bit 31.
- frame_valid  out  1  one-cycle pulse when a complete frame is accepted.
- frame_err  out  1  one-cycle pulse when a started frame is aborted.
- busy  out  1  high from the leader mark start until the frame completes or aborts.
- led_out  out  1  toggles on every frame_valid.

## Operation
- Input conditioning: 2-FF synchronizer, then a stable-level filter. The filtered level changes only after the synchronized level has differed from it for GLITCH consecutive cycles. The filtered level resets to 1.
- Duration measurement: the tick prescaler and a 12-bit tick counter both clear on every filtered edge. The counter saturates at 4095. On each edge, the duration of the segment that just ended is classified by window (ticks, inclusive):
  - leader mark 800–1000
  - leader space 400–500
  - bit mark 40–80
  - zero space 40–80
  - one space 140–200
  - connector space 1800–2200
- FSM states:
  - IDLE: a filtered falling edge goes to LEAD_MARK.
  - LEAD_MARK: a rising edge with a leader mark duration goes to LEAD_SPACE.
  - LEAD_SPACE: a falling edge with a leader space duration goes to MARK, with seg=0 and cnt=0.
  - MARK: on a rising edge with a bit mark duration:
    - seg=1 and cnt=32: accept the frame and go to IDLE.
    - otherwise go to SPACE.
  - SPACE: on a falling edge:
    - seg=0 and cnt=35 with a connector space: set seg=1, cnt=0, go to MARK.
    - cnt below the segment length (35 or 32) with a zero or one space: shift the bit into that segment's shift register, cnt+1, go to MARK.
- Any duration outside its expected window is an error: frame_err pulses, the FSM returns to IDLE, and data outputs are unchanged.
- In any non-IDLE state, a tick counter reaching TIMEOUT is also an error with the same effect.
- Accept: copy both shift registers to data35_out and data32_out, pulse frame_valid, toggle led_out.
- Shift registers shift left; cnt is 6 bits.

## Timing
- Reset values: data35_out=0, data32_out=0, frame_valid=0, frame_err=0, busy=0, led_out=0, FSM=IDLE, filtered level=1, counters=0.
- Reset asserted mid-frame discards the frame immediately, with no frame_err pulse.
- Pin-to-filtered-edge latency: 2+GLITCH cycles.
- frame_valid, the data update, and the led_out toggle all occur on the same clock edge, 1 cycle after the filtered rising edge that ends the end mark.
- data outputs remain stable until the next valid frame.
- frame_err asserts 1 cycle after the offending filtered edge, or on the cycle the timeout count is reached.
- busy rises with the transition out of IDLE and falls in the cycle frame_valid or frame_err pulses.
- A falling edge arriving in the same cycle as the timeout is handled as the timeout. The FSM returns to IDLE and does not treat that edge as a new leader; the leader is taken from the next falling edge.
- Measurement resolution is ±1 tick; window edges are inclusive.

## Test plan
- Reset then clean frame: 9 ms leader mark, 4.5 ms space, data35=35'h7C1F07C1F (each 1 as 560 µs mark + 1690 µs space, each 0 as 560 µs mark + 560 µs space), 560 µs mark, 20 ms connector, data32=32'hF83E0F83, 560 µs end mark → one frame_valid, outputs equal these values, led_out=1, busy low afterwards.
- Glitches: inject 100 ns low pulses during spaces, and the same 100 ns low pulses throughout IDLE → no state change; a subsequent clean frame decodes correctly.
- Bad leader: 5 ms leader mark → no frame_err, FSM back to IDLE when that mark ends, outputs unchanged; the next clean frame decodes.
- Bad bit: bit 10 space of 1.1 ms (110 ticks) → frame_err pulse, previous data retained, no led_out toggle.
- Truncated frame: stop after 20 bits of the second segment with the line idle high → frame_err exactly 25 ms after the last edge, busy falls.
- Reset mid-frame: assert rst during the connector space → all outputs at reset values, no frame_err; a following clean frame decodes.
